// File: rtl/wm_extraction_pkg.sv
// Shared constants for the watermark extraction path.
// Symbol geometry and block position encoding.
package wm_extraction_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int SYM_W         = 2;
  localparam int SYMS_PER_BYTE = 4;
  localparam int PIX_PER_SYM   = 4;

  typedef logic [SYM_W-1:0] sym_t;

  localparam logic [1:0] P1 = 2'd0;
  localparam logic [1:0] P2 = 2'd1;
  localparam logic [1:0] P3 = 2'd2;
  localparam logic [1:0] P4 = 2'd3;

  function automatic logic [1:0] err_sum(input logic e1, input logic e0);
    return {1'b0, e1} + {1'b0, e0};
  endfunction

endpackage

// File: rtl/wm_sat_counter.sv
// Saturating event counter with synchronous clear.
// Adds 0, 1 or 2 per cycle and sticks at all-ones.
module wm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W+1:0] MAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W+1:0] sum;

  assign sum = {2'b00, count} + {{CNT_W{1'b0}}, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sum > MAX) begin
      count <= {CNT_W{1'b1}};
    end else begin
      count <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/wm_extraction.sv
// Watermark extraction: recovers 2-bit symbols from pixel LSB
// pairs, checks them and packs four symbols per output byte.
module wm_extraction
  import wm_extraction_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             frame_start,
  input  logic [1:0]       exp_sym,
  output logic             exp_adv,
  output logic [1:0]       sym_out,
  output logic             sym_valid,
  output logic             sym_err,
  output logic [7:0]       wm_byte,
  output logic             wm_valid,
  input  logic             wm_ready,
  output logic [CNT_W-1:0] pair_err_cnt,
  output logic [CNT_W-1:0] sym_mis_cnt
);

  logic [1:0] pos;
  logic       a;
  logic       bit1;
  logic       pe1;
  logic [1:0] scnt;
  logic [5:0] sh;

  logic       accept;
  logic       lsb;
  logic       done;
  logic       pe_now;
  logic       mis;
  logic       clear;
  sym_t       sym_new;
  logic [1:0] pair_inc;
  logic       pix_unused;

  assign pix_ready  = !wm_valid || wm_ready;
  assign accept     = pix_valid && pix_ready;
  assign lsb        = pix_in[0];
  assign pix_unused = ^pix_in[PIX_W-1:1];
  assign pe_now     = lsb != a;
  assign sym_new    = {bit1, a};
  assign mis        = sym_new != exp_sym;

  // A frame_start pixel is always P1, so it never completes a symbol.
  assign done     = accept && !frame_start && (pos == P4);
  assign clear    = accept && frame_start;
  assign pair_inc = done ? err_sum(pe1, pe_now) : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= P1;
      a         <= 1'b0;
      bit1      <= 1'b0;
      pe1       <= 1'b0;
      scnt      <= 2'd0;
      sh        <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      exp_adv   <= 1'b0;
      wm_byte   <= '0;
      wm_valid  <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      exp_adv   <= 1'b0;
      if (wm_valid && wm_ready) begin
        wm_valid <= 1'b0;
      end
      if (accept) begin
        if (frame_start) begin
          a    <= lsb;
          pos  <= P2;
          scnt <= 2'd0;
          sh   <= '0;
        end else begin
          unique case (pos)
            P1: begin
              a   <= lsb;
              pos <= P2;
            end
            P2: begin
              bit1 <= a;
              pe1  <= pe_now;
              pos  <= P3;
            end
            P3: begin
              a   <= lsb;
              pos <= P4;
            end
            P4: begin
              pos       <= P1;
              sym_out   <= sym_new;
              sym_valid <= 1'b1;
              exp_adv   <= 1'b1;
              sym_err   <= pe1 || pe_now || mis;
              scnt      <= scnt + 2'd1;
              if (scnt == 2'(SYMS_PER_BYTE - 1)) begin
                wm_byte  <= {sh, sym_new};
                wm_valid <= 1'b1;
              end else begin
                sh <= {sh[3:0], sym_new};
              end
            end
          endcase
        end
      end
    end
  end

  wm_sat_counter #(.CNT_W(CNT_W)) u_pair_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (pair_inc),
    .count (pair_err_cnt)
  );

  wm_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   ({1'b0, done && mis}),
    .count (sym_mis_cnt)
  );

endmodule

// File: tb/tb_wm_extraction.sv
// Bench for wm_extraction: scoreboarded symbols and bytes,
// stall, frame_start, saturation and async reset scenarios.
module tb_wm_extraction;

  typedef struct {
    logic [1:0] sym;
    logic       err;
    int         pc;
    int         mc;
    int         pc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  exp_sym = '0;
  logic        wm_ready = 1'b1;

  logic        pix_ready, exp_adv, sym_valid, sym_err, wm_valid;
  logic [1:0]  sym_out;
  logic [7:0]  wm_byte;
  logic [15:0] pair_err_cnt, sym_mis_cnt;

  logic        s_pix_ready, s_exp_adv, s_sym_valid, s_sym_err, s_wm_valid;
  logic [1:0]  s_sym_out;
  logic [7:0]  s_wm_byte;
  logic [1:0]  s_pair_cnt, s_mis_cnt;

  int checks = 0;
  int failures = 0;
  int nsym = 0;

  exp_t       sq[$];
  logic [7:0] bq[$];

  int         tpos, tscnt, tpc, tmc, tpc2;
  logic       ta, tb1, tpe1;
  logic [7:0] tsh;

  always #5 clk = ~clk;

  wm_extraction #(.PIX_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_start(frame_start),
    .exp_sym(exp_sym), .exp_adv(exp_adv), .sym_out(sym_out),
    .sym_valid(sym_valid), .sym_err(sym_err), .wm_byte(wm_byte),
    .wm_valid(wm_valid), .wm_ready(wm_ready),
    .pair_err_cnt(pair_err_cnt), .sym_mis_cnt(sym_mis_cnt)
  );

  wm_extraction #(.PIX_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(s_pix_ready), .frame_start(frame_start),
    .exp_sym(exp_sym), .exp_adv(s_exp_adv), .sym_out(s_sym_out),
    .sym_valid(s_sym_valid), .sym_err(s_sym_err), .wm_byte(s_wm_byte),
    .wm_valid(s_wm_valid), .wm_ready(wm_ready),
    .pair_err_cnt(s_pair_cnt), .sym_mis_cnt(s_mis_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    sq.delete();
    bq.delete();
    tpos = 0; tscnt = 0; tpc = 0; tmc = 0; tpc2 = 0;
    ta = 0; tb1 = 0; tpe1 = 0; tsh = '0;
  endtask

  task automatic model_pix(input logic lsb, input logic fs,
                           input logic [1:0] es);
    exp_t e;
    logic pe0;
    int   n;
    if (fs) begin
      tpos = 0; tscnt = 0; tsh = '0;
      tpc = 0; tmc = 0; tpc2 = 0;
    end
    case (tpos)
      0: ta = lsb;
      1: begin
        tb1  = ta;
        tpe1 = (lsb != ta);
      end
      2: ta = lsb;
      default: begin
        pe0   = (lsb != ta);
        e.sym = {tb1, ta};
        e.err = tpe1 | pe0 | (e.sym != es);
        n     = int'(tpe1) + int'(pe0);
        tpc   = sat(tpc + n, 65535);
        tpc2  = sat(tpc2 + n, 3);
        if (e.sym != es) tmc = sat(tmc + 1, 65535);
        e.pc  = tpc;
        e.mc  = tmc;
        e.pc2 = tpc2;
        sq.push_back(e);
        tsh = {tsh[5:0], e.sym};
        if (tscnt == 3) bq.push_back(tsh);
        tscnt = (tscnt + 1) % 4;
      end
    endcase
    tpos = (tpos + 1) % 4;
  endtask

  task automatic drive_pix(input logic lsb, input logic fs,
                           input logic [1:0] es);
    logic [7:0] r;
    int         n;
    @(negedge clk);
    r = 8'($urandom);
    r[0] = lsb;
    pix_in = r;
    pix_valid = 1'b1;
    frame_start = fs;
    exp_sym = es;
    #1;
    n = 0;
    while (!pix_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!pix_ready) chk("pix_ready_timeout", pix_ready, 1);
    model_pix(lsb, fs, es);
    @(posedge clk);
  endtask

  task automatic drive_blk(input logic [3:0] l, input logic [1:0] es,
                           input logic fs);
    drive_pix(l[3], fs, es);
    drive_pix(l[2], 1'b0, es);
    drive_pix(l[1], 1'b0, es);
    drive_pix(l[0], 1'b0, es);
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
    frame_start = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (sym_valid || exp_adv) begin
        nsym++;
        chk("exp_adv", exp_adv, 1);
        chk("sym_valid", sym_valid, 1);
        if (sq.size() == 0) begin
          chk("sym_q_depth", sq.size(), 1);
        end else begin
          e = sq.pop_front();
          chk("sym_out", sym_out, e.sym);
          chk("sym_err", sym_err, e.err);
          chk("pair_cnt", pair_err_cnt, e.pc);
          chk("mis_cnt", sym_mis_cnt, e.mc);
          chk("pair_cnt_w2", s_pair_cnt, e.pc2);
        end
      end
      if (wm_valid && wm_ready) begin
        if (bq.size() == 0) chk("byte_q_depth", bq.size(), 1);
        else chk("wm_byte", wm_byte, bq.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sym_out", sym_out, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_err", sym_err, 0);
    chk("rst_exp_adv", exp_adv, 0);
    chk("rst_wm_byte", wm_byte, 0);
    chk("rst_wm_valid", wm_valid, 0);
    chk("rst_pair", pair_err_cnt, 0);
    chk("rst_mis", sym_mis_cnt, 0);
    chk("rst_pix_ready", pix_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // four clean 2'b10 symbols
    for (int i = 0; i < 16; i++) drive_pix((i % 4) < 2, 1'b0, 2'b10);
    idle();
    chk("t1_wm_valid", wm_valid, 1);
    chk("t1_wm_byte", wm_byte, 8'hAA);
    chk("t1_pair", pair_err_cnt, 0);
    chk("t1_mis", sym_mis_cnt, 0);
    @(negedge clk);
    #1;
    chk("t1_nsym", nsym, 4);

    // pair error plus mismatch
    drive_blk(4'b1011, 2'b01, 1'b0);
    idle();
    chk("t2_sym_out", sym_out, 2'b11);
    chk("t2_sym_err", sym_err, 1);
    chk("t2_pair", pair_err_cnt, 1);
    chk("t2_mis", sym_mis_cnt, 1);

    // byte stall
    wm_ready = 1'b0;
    drive_blk(4'b0000, 2'b00, 1'b0);
    drive_blk(4'b1111, 2'b11, 1'b0);
    drive_blk(4'b0011, 2'b01, 1'b0);
    @(negedge clk);
    pix_in = 8'h01;
    pix_valid = 1'b1;
    frame_start = 1'b0;
    exp_sym = 2'b00;
    #1;
    chk("t3_wm_valid", wm_valid, 1);
    chk("t3_wm_byte", wm_byte, 8'hCD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t3_stall_ready", pix_ready, 0);
      chk("t3_byte_stable", wm_byte, 8'hCD);
    end
    model_pix(1'b1, 1'b0, 2'b00);
    @(negedge clk);
    wm_ready = 1'b1;
    @(negedge clk);
    wm_ready = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("t3_valid_drop", wm_valid, 0);
    chk("t3_ready_back", pix_ready, 1);
    wm_ready = 1'b1;

    // frame_start on the 7th pixel
    drive_blk(4'b1011, 2'b00, 1'b1);
    drive_pix(1'b0, 1'b0, 2'b00);
    drive_pix(1'b1, 1'b0, 2'b00);
    drive_pix(1'b1, 1'b1, 2'b11);
    idle();
    chk("t4_pair_clr", pair_err_cnt, 0);
    chk("t4_mis_clr", sym_mis_cnt, 0);
    drive_pix(1'b1, 1'b0, 2'b11);
    drive_pix(1'b1, 1'b0, 2'b11);
    drive_pix(1'b1, 1'b0, 2'b11);
    drive_blk(4'b0000, 2'b00, 1'b0);
    drive_blk(4'b0011, 2'b01, 1'b0);
    drive_blk(4'b1100, 2'b10, 1'b0);
    idle();
    chk("t4_wm_valid", wm_valid, 1);
    chk("t4_wm_byte", wm_byte, 8'hC6);

    // saturation with both pairs failing
    drive_blk(4'b1010, 2'b11, 1'b1);
    idle();
    chk("t5_sat_a", s_pair_cnt, 2);
    chk("t5_wide_a", pair_err_cnt, 2);
    drive_blk(4'b1010, 2'b11, 1'b0);
    idle();
    chk("t5_sat_b", s_pair_cnt, 3);
    chk("t5_wide_b", pair_err_cnt, 4);
    drive_blk(4'b1010, 2'b11, 1'b0);
    idle();
    chk("t5_sat_c", s_pair_cnt, 3);
    chk("t5_wide_c", pair_err_cnt, 6);
    chk("t5_mis", sym_mis_cnt, 0);

    // async reset mid-block
    drive_pix(1'b1, 1'b0, 2'b00);
    drive_pix(1'b1, 1'b0, 2'b00);
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_sym_out", sym_out, 0);
    chk("ar_wm_byte", wm_byte, 0);
    chk("ar_pair", pair_err_cnt, 0);
    chk("ar_pair_w2", s_pair_cnt, 0);
    chk("ar_pix_ready", pix_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_blk(4'b0011, 2'b01, 1'b0);
    idle();
    chk("ar_first_sym", sym_out, 2'b01);
    chk("ar_first_err", sym_err, 0);
    @(negedge clk);
    #1;
    chk("end_sym_q", sq.size(), 0);
    chk("end_byte_q", bq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
